// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the I-cache/D-cache main-memory arbiter: FSM encoding,
// requester identifiers and the line-offset width helper.
package cache_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_FILL    = 3'd2,
      ST_WAIT_WR = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic REQ_IC = 1'b0;
   localparam logic REQ_DC = 1'b1;

   // Byte-address bits covered by one cache line (word offset plus byte offset).
   function automatic int line_off_width(input int number_word);
      return $clog2(number_word) + 2;
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin: on a tie, the requester that did not win last
// time is granted. Grant is one-hot, bit REQ_IC for the I-cache, bit REQ_DC for the D-cache.
module cache_mem_arbiter_rr_arbiter_2
   import cache_mem_arbiter_pkg::*;
(
   input  logic       req_ic,
   input  logic       req_dc,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      if (req_ic && req_dc) begin
         if (last_grant == REQ_DC) grant[REQ_IC] = 1'b1;
         else                      grant[REQ_DC] = 1'b1;
      end else if (req_ic) begin
         grant[REQ_IC] = 1'b1;
      end else if (req_dc) begin
         grant[REQ_DC] = 1'b1;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single main-memory port between I-cache line refills and D-cache
// refills / write-through, assembling refill beats into a full line.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int WIDTH_DATA  = 32,
   parameter int NUMBER_WORD = 8,
   parameter int WIDTH_ADD   = 32
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              IC_Req_Valid,
   input  logic [WIDTH_ADD-1:0]              IC_Req_ADD,
   output logic                              IC_Grant,
   output logic [WIDTH_DATA*NUMBER_WORD-1:0] IC_Line_Data,
   output logic                              IC_Line_Valid,
   input  logic                              DC_Req_Valid,
   input  logic                              DC_Req_WR,
   input  logic [WIDTH_ADD-1:0]              DC_Req_ADD,
   input  logic [WIDTH_DATA-1:0]             DC_Req_WData,
   output logic                              DC_Grant,
   output logic [WIDTH_DATA*NUMBER_WORD-1:0] DC_Line_Data,
   output logic                              DC_Line_Valid,
   output logic                              DC_WR_Done,
   output logic                              MEM_Req_Valid,
   input  logic                              MEM_Req_Ready,
   output logic                              MEM_Req_WR,
   output logic [WIDTH_ADD-1:0]              MEM_Req_ADD,
   output logic [WIDTH_DATA-1:0]             MEM_Req_WData,
   input  logic                              MEM_RD_Valid,
   input  logic [WIDTH_DATA-1:0]             MEM_RD_Data,
   input  logic                              MEM_WR_Ack,
   output logic [2:0]                        dbg_state
);

   localparam int CW    = $clog2(NUMBER_WORD);
   localparam int OFF_W = line_off_width(NUMBER_WORD);
   localparam logic [WIDTH_ADD-1:0] RD_MASK   = {WIDTH_ADD{1'b1}} << OFF_W;
   localparam logic [WIDTH_ADD-1:0] WR_MASK   = {WIDTH_ADD{1'b1}} << 2;
   localparam logic [CW-1:0]        LAST_BEAT = CW'(NUMBER_WORD - 1);

   state_t                                    state, state_nxt;
   logic                                      req_id;
   logic                                      req_wr;
   logic [WIDTH_ADD-1:0]                      req_add;
   logic [WIDTH_DATA-1:0]                     req_wdata;
   logic                                      last_grant;
   logic [CW-1:0]                             beat_cnt;
   logic [NUMBER_WORD-1:0][WIDTH_DATA-1:0]    line_buf;
   logic [1:0]                                arb_grant;
   logic                                      accept;

   cache_mem_arbiter_rr_arbiter_2 u_rr_arbiter_2 (
      .req_ic     (IC_Req_Valid),
      .req_dc     (DC_Req_Valid),
      .last_grant (last_grant),
      .grant      (arb_grant)
   );

   assign accept    = (state == ST_IDLE) && (|arb_grant);
   assign dbg_state = state;

   // Memory command: valid/ready handshake. MEM_Req_Valid stays high with the
   // address, op and write data frozen until the cycle MEM_Req_Ready is sampled high.
   always_comb begin
      state_nxt     = state;
      IC_Grant      = 1'b0;
      DC_Grant      = 1'b0;
      IC_Line_Valid = 1'b0;
      DC_Line_Valid = 1'b0;
      DC_WR_Done    = 1'b0;
      MEM_Req_Valid = 1'b0;
      MEM_Req_WR    = 1'b0;
      MEM_Req_ADD   = '0;
      MEM_Req_WData = '0;
      IC_Line_Data  = line_buf;
      DC_Line_Data  = line_buf;

      if (state != ST_IDLE) begin
         IC_Grant = (req_id == REQ_IC);
         DC_Grant = (req_id == REQ_DC);
      end

      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            MEM_Req_Valid = 1'b1;
            MEM_Req_WR    = req_wr;
            MEM_Req_ADD   = req_add & (req_wr ? WR_MASK : RD_MASK);
            MEM_Req_WData = req_wr ? req_wdata : '0;
            if (MEM_Req_Ready) state_nxt = req_wr ? ST_WAIT_WR : ST_FILL;
         end
         ST_FILL: begin
            if (MEM_RD_Valid && (beat_cnt == LAST_BEAT)) state_nxt = ST_DONE;
         end
         ST_WAIT_WR: begin
            if (MEM_WR_Ack) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            IC_Line_Valid = (req_id == REQ_IC);
            DC_Line_Valid = (req_id == REQ_DC) && !req_wr;
            DC_WR_Done    = (req_id == REQ_DC) && req_wr;
            state_nxt     = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         req_id     <= REQ_IC;
         req_wr     <= 1'b0;
         req_add    <= '0;
         req_wdata  <= '0;
         last_grant <= REQ_DC;
         beat_cnt   <= '0;
         line_buf   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_id     <= arb_grant[REQ_DC] ? REQ_DC : REQ_IC;
            last_grant <= arb_grant[REQ_DC] ? REQ_DC : REQ_IC;
            req_wr     <= arb_grant[REQ_DC] ? DC_Req_WR : 1'b0;
            req_add    <= arb_grant[REQ_DC] ? DC_Req_ADD : IC_Req_ADD;
            req_wdata  <= arb_grant[REQ_DC] ? DC_Req_WData : '0;
         end
         // Beats only count while filling; strays in other states are dropped.
         if ((state == ST_FILL) && MEM_RD_Valid) begin
            line_buf[beat_cnt] <= MEM_RD_Data;
            beat_cnt           <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: per-cycle vector table for a refill and a
// write, then hand sequences for contention, gapped beats, requester drop and reset.
module tb_cache_mem_arbiter;

   localparam int WD = 32;
   localparam int NW = 8;
   localparam int WA = 32;
   localparam int LW = WD * NW;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_FILL = 3'd2;
   localparam logic [2:0] S_WWR  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [LW-1:0] IC_LINE =
      256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          IC_Req_Valid = 1'b0;
   logic [WA-1:0] IC_Req_ADD = '0;
   logic          IC_Grant;
   logic [LW-1:0] IC_Line_Data;
   logic          IC_Line_Valid;
   logic          DC_Req_Valid = 1'b0;
   logic          DC_Req_WR = 1'b0;
   logic [WA-1:0] DC_Req_ADD = '0;
   logic [WD-1:0] DC_Req_WData = '0;
   logic          DC_Grant;
   logic [LW-1:0] DC_Line_Data;
   logic          DC_Line_Valid;
   logic          DC_WR_Done;
   logic          MEM_Req_Valid;
   logic          MEM_Req_Ready = 1'b0;
   logic          MEM_Req_WR;
   logic [WA-1:0] MEM_Req_ADD;
   logic [WD-1:0] MEM_Req_WData;
   logic          MEM_RD_Valid = 1'b0;
   logic [WD-1:0] MEM_RD_Data = '0;
   logic          MEM_WR_Ack = 1'b0;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   cache_mem_arbiter #(.WIDTH_DATA(WD), .NUMBER_WORD(NW), .WIDTH_ADD(WA)) dut (
      .CLK(CLK), .RST(RST),
      .IC_Req_Valid(IC_Req_Valid), .IC_Req_ADD(IC_Req_ADD), .IC_Grant(IC_Grant),
      .IC_Line_Data(IC_Line_Data), .IC_Line_Valid(IC_Line_Valid),
      .DC_Req_Valid(DC_Req_Valid), .DC_Req_WR(DC_Req_WR), .DC_Req_ADD(DC_Req_ADD),
      .DC_Req_WData(DC_Req_WData), .DC_Grant(DC_Grant), .DC_Line_Data(DC_Line_Data),
      .DC_Line_Valid(DC_Line_Valid), .DC_WR_Done(DC_WR_Done),
      .MEM_Req_Valid(MEM_Req_Valid), .MEM_Req_Ready(MEM_Req_Ready),
      .MEM_Req_WR(MEM_Req_WR), .MEM_Req_ADD(MEM_Req_ADD), .MEM_Req_WData(MEM_Req_WData),
      .MEM_RD_Valid(MEM_RD_Valid), .MEM_RD_Data(MEM_RD_Data), .MEM_WR_Ack(MEM_WR_Ack),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_l(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RST) begin
         checks++;
         if (IC_Grant && DC_Grant) begin
            errors++;
            $display("FAIL grant_overlap: got IC=1 DC=1 expected at most one");
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      IC_Req_Valid  = 1'b0;
      DC_Req_Valid  = 1'b0;
      DC_Req_WR     = 1'b0;
      MEM_Req_Ready = 1'b0;
      MEM_RD_Valid  = 1'b0;
      MEM_RD_Data   = '0;
      MEM_WR_Ack    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk_w({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
      chk_b({tag, "_ic_grant"}, IC_Grant, 1'b0);
      chk_b({tag, "_dc_grant"}, DC_Grant, 1'b0);
      chk_b({tag, "_ic_lv"}, IC_Line_Valid, 1'b0);
      chk_b({tag, "_dc_lv"}, DC_Line_Valid, 1'b0);
      chk_b({tag, "_dc_wd"}, DC_WR_Done, 1'b0);
      chk_b({tag, "_mem_v"}, MEM_Req_Valid, 1'b0);
      chk_b({tag, "_mem_wr"}, MEM_Req_WR, 1'b0);
      chk_w({tag, "_mem_add"}, MEM_Req_ADD, '0);
      chk_w({tag, "_mem_wdata"}, MEM_Req_WData, '0);
      chk_l({tag, "_ic_line"}, IC_Line_Data, '0);
      chk_l({tag, "_dc_line"}, DC_Line_Data, '0);
   endtask

   task automatic do_reset();
      RST = 1'b0;
      idle_inputs();
      repeat (2) tick();
      RST = 1'b1;
      tick();
   endtask

   task automatic serve_req();
      MEM_Req_Ready = 1'b1;
      tick();
      MEM_Req_Ready = 1'b0;
   endtask

   task automatic send_beats(input logic [WD-1:0] base, input int gap, output logic [LW-1:0] line);
      line = '0;
      for (int i = 0; i < NW; i++) begin
         MEM_RD_Valid = 1'b1;
         MEM_RD_Data  = base + WD'(i);
         line[i*WD +: WD] = base + WD'(i);
         tick();
         MEM_RD_Valid = 1'b0;
         if (i < NW - 1) repeat (gap) tick();
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          ic_v, dc_v, dc_wr, rdy, rd_v, ack;
      logic [WD-1:0] rd_data;
      logic [2:0]    e_st;
      logic          e_mv, e_mwr;
      logic [WA-1:0] e_madd;
      logic [WD-1:0] e_wdata;
      logic          e_ic_g, e_dc_g, e_ic_lv, e_dc_lv, e_wd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic ic_v, dc_v, dc_wr, rdy, rd_v, ack,
                               input logic [WD-1:0] rd_data, input logic [2:0] e_st,
                               input logic e_mv, e_mwr, input logic [WA-1:0] e_madd,
                               input logic [WD-1:0] e_wdata,
                               input logic e_ic_g, e_dc_g, e_ic_lv, e_dc_lv, e_wd);
      vec_t r;
      r.ic_v = ic_v; r.dc_v = dc_v; r.dc_wr = dc_wr; r.rdy = rdy; r.rd_v = rd_v; r.ack = ack;
      r.rd_data = rd_data; r.e_st = e_st; r.e_mv = e_mv; r.e_mwr = e_mwr;
      r.e_madd = e_madd; r.e_wdata = e_wdata; r.e_ic_g = e_ic_g; r.e_dc_g = e_dc_g;
      r.e_ic_lv = e_ic_lv; r.e_dc_lv = e_dc_lv; r.e_wd = e_wd;
      return r;
   endfunction

   initial begin
      logic [LW-1:0] line;

      // IC refill of 0x1234: ready at once, beats 0x11..0x88 back to back.
      vecs.push_back(mk(T,F,F, F,F,F, '0,     S_REQ,  T,F,32'h1220,'0, T,F,F,F,F));
      vecs.push_back(mk(T,F,F, T,F,F, '0,     S_FILL, F,F,'0,'0,       T,F,F,F,F));
      for (int k = 1; k <= 7; k++)
         vecs.push_back(mk(T,F,F, F,T,F, 32'(k*17), S_FILL, F,F,'0,'0, T,F,F,F,F));
      vecs.push_back(mk(T,F,F, F,T,F, 32'h88, S_DONE, F,F,'0,'0,       T,F,T,F,F));
      vecs.push_back(mk(F,F,F, F,F,F, '0,     S_IDLE, F,F,'0,'0,       F,F,F,F,F));
      // DC write of 0x2006: ready on 4th REQ cycle, stray ack in REQ, stray beat in WAIT_WR.
      vecs.push_back(mk(F,T,T, F,F,F, '0, S_REQ,  T,T,32'h2004,32'hDEADBEEF, F,T,F,F,F));
      vecs.push_back(mk(F,T,T, F,F,F, '0, S_REQ,  T,T,32'h2004,32'hDEADBEEF, F,T,F,F,F));
      vecs.push_back(mk(F,T,T, F,F,T, '0, S_REQ,  T,T,32'h2004,32'hDEADBEEF, F,T,F,F,F));
      vecs.push_back(mk(F,T,T, F,F,F, '0, S_REQ,  T,T,32'h2004,32'hDEADBEEF, F,T,F,F,F));
      vecs.push_back(mk(F,T,T, T,F,F, '0, S_WWR,  F,F,'0,'0,                 F,T,F,F,F));
      vecs.push_back(mk(F,T,T, F,T,F, 32'h5A, S_WWR, F,F,'0,'0,              F,T,F,F,F));
      vecs.push_back(mk(F,T,T, F,F,T, '0, S_DONE, F,F,'0,'0,                 F,T,F,F,T));
      vecs.push_back(mk(F,F,F, F,F,F, '0, S_IDLE, F,F,'0,'0,                 F,F,F,F,F));

      // Power-on reset.
      idle_inputs();
      repeat (2) tick();
      check_reset_outputs("por");
      RST = 1'b1;
      tick();
      chk_w("por_release_state", 32'(dbg_state), 32'(S_IDLE));

      IC_Req_ADD   = 32'h0000_1234;
      DC_Req_ADD   = 32'h0000_2006;
      DC_Req_WData = 32'hDEADBEEF;
      foreach (vecs[i]) begin
         IC_Req_Valid  = vecs[i].ic_v;
         DC_Req_Valid  = vecs[i].dc_v;
         DC_Req_WR     = vecs[i].dc_wr;
         MEM_Req_Ready = vecs[i].rdy;
         MEM_RD_Valid  = vecs[i].rd_v;
         MEM_RD_Data   = vecs[i].rd_data;
         MEM_WR_Ack    = vecs[i].ack;
         tick();
         chk_w($sformatf("v%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_st));
         chk_b($sformatf("v%0d_mem_v", i), MEM_Req_Valid, vecs[i].e_mv);
         chk_b($sformatf("v%0d_ic_g", i), IC_Grant, vecs[i].e_ic_g);
         chk_b($sformatf("v%0d_dc_g", i), DC_Grant, vecs[i].e_dc_g);
         chk_b($sformatf("v%0d_ic_lv", i), IC_Line_Valid, vecs[i].e_ic_lv);
         chk_b($sformatf("v%0d_dc_lv", i), DC_Line_Valid, vecs[i].e_dc_lv);
         chk_b($sformatf("v%0d_dc_wd", i), DC_WR_Done, vecs[i].e_wd);
         if (vecs[i].e_mv) begin
            chk_b($sformatf("v%0d_mem_wr", i), MEM_Req_WR, vecs[i].e_mwr);
            chk_w($sformatf("v%0d_mem_add", i), MEM_Req_ADD, vecs[i].e_madd);
            if (vecs[i].e_mwr)
               chk_w($sformatf("v%0d_mem_wdata", i), MEM_Req_WData, vecs[i].e_wdata);
         end
         if (vecs[i].e_ic_lv) chk_l($sformatf("v%0d_ic_line", i), IC_Line_Data, IC_LINE);
      end
      idle_inputs();

      // Contention out of reset: both keep requesting, grants alternate IC, DC, IC, DC.
      do_reset();
      IC_Req_ADD   = 32'h0000_4000;
      DC_Req_ADD   = 32'h0000_5000;
      IC_Req_Valid = 1'b1;
      DC_Req_Valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic exp_ic;
         exp_ic = (k % 2 == 0);
         tick();
         chk_b($sformatf("cont%0d_ic_g", k), IC_Grant, exp_ic);
         chk_b($sformatf("cont%0d_dc_g", k), DC_Grant, !exp_ic);
         chk_w($sformatf("cont%0d_add", k), MEM_Req_ADD, exp_ic ? 32'h4000 : 32'h5000);
         serve_req();
         send_beats(32'h1000 * WD'(k + 1), 0, line);
         chk_b($sformatf("cont%0d_ic_lv", k), IC_Line_Valid, exp_ic);
         chk_b($sformatf("cont%0d_dc_lv", k), DC_Line_Valid, !exp_ic);
         chk_l($sformatf("cont%0d_line", k), exp_ic ? IC_Line_Data : DC_Line_Data, line);
         tick();
         chk_w($sformatf("cont%0d_idle", k), 32'(dbg_state), 32'(S_IDLE));
      end
      IC_Req_Valid = 1'b0;
      DC_Req_Valid = 1'b0;

      // Gapped beats with a stray beat during REQ.
      IC_Req_ADD   = 32'h0000_3048;
      IC_Req_Valid = 1'b1;
      tick();
      chk_w("gap_add", MEM_Req_ADD, 32'h0000_3040);
      MEM_RD_Valid = 1'b1;
      MEM_RD_Data  = 32'hBAD0BAD0;
      tick();
      chk_w("gap_stray_state", 32'(dbg_state), 32'(S_REQ));
      MEM_RD_Valid = 1'b0;
      serve_req();
      send_beats(32'h0000_00A0, 2, line);
      chk_b("gap_ic_lv", IC_Line_Valid, 1'b1);
      chk_l("gap_line", IC_Line_Data, line);
      IC_Req_Valid = 1'b0;
      tick();

      // DC refill; DC drops its request mid-fill while IC starts requesting.
      DC_Req_WR    = 1'b0;
      DC_Req_ADD   = 32'h0000_6010;
      DC_Req_Valid = 1'b1;
      tick();
      chk_b("drop_dc_g", DC_Grant, 1'b1);
      chk_w("drop_add", MEM_Req_ADD, 32'h0000_6000);
      serve_req();
      line = '0;
      for (int i = 0; i < NW; i++) begin
         if (i == 3) begin
            DC_Req_Valid = 1'b0;
            IC_Req_ADD   = 32'h0000_7000;
            IC_Req_Valid = 1'b1;
         end
         MEM_RD_Valid = 1'b1;
         MEM_RD_Data  = 32'h0000_0D00 + WD'(i);
         line[i*WD +: WD] = 32'h0000_0D00 + WD'(i);
         tick();
      end
      MEM_RD_Valid = 1'b0;
      chk_b("drop_dc_lv", DC_Line_Valid, 1'b1);
      chk_b("drop_ic_g_wait", IC_Grant, 1'b0);
      chk_l("drop_line", DC_Line_Data, line);
      tick();
      chk_w("drop_idle", 32'(dbg_state), 32'(S_IDLE));
      tick();
      chk_b("drop_ic_granted", IC_Grant, 1'b1);
      chk_w("drop_ic_add", MEM_Req_ADD, 32'h0000_7000);

      // Reset mid-fill after 3 beats, then a fresh IC refill.
      serve_req();
      for (int i = 0; i < 3; i++) begin
         MEM_RD_Valid = 1'b1;
         MEM_RD_Data  = 32'h0000_0055 + WD'(i);
         tick();
      end
      chk_w("rst_pre_state", 32'(dbg_state), 32'(S_FILL));
      #2 RST = 1'b0;
      #1 check_reset_outputs("midfill");
      IC_Req_Valid = 1'b0;
      MEM_RD_Data  = 32'h0000_00FF;
      tick();
      RST = 1'b1;
      tick();
      chk_w("rst_stray_state", 32'(dbg_state), 32'(S_IDLE));
      chk_l("rst_stray_line", IC_Line_Data, '0);
      MEM_RD_Valid = 1'b0;
      IC_Req_ADD   = 32'h0000_8000;
      IC_Req_Valid = 1'b1;
      tick();
      chk_b("rst_ic_g", IC_Grant, 1'b1);
      chk_l("rst_fresh_buf", IC_Line_Data, '0);
      serve_req();
      send_beats(32'h0000_00C0, 0, line);
      chk_b("rst_ic_lv", IC_Line_Valid, 1'b1);
      chk_l("rst_line", IC_Line_Data, line);
      IC_Req_Valid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache line-refill path and the D-cache path.
- D-cache path carries line refills and single-word write-through.
- Arbitrates between the two requesters with 2-way round-robin.
- Sequences the memory handshake, counts refill beats, assembles a full line (NUMBER_WORD words) and returns it to the granted requester with a one-cycle valid pulse.

Parameters:
WIDTH_DATA, 32, word width in bits
NUMBER_WORD, 8, words per cache line; power of two, at least 2
WIDTH_ADD, 32, address width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
IC_Req_Valid  input  1  I-cache line-refill request; held high until IC_Line_Valid
IC_Req_ADD  input  WIDTH_ADD  I-cache miss address
IC_Grant  output  1  I-cache transaction in progress
IC_Line_Data  output  WIDTH_DATA*NUMBER_WORD  refilled line; word 0 in LSBs
IC_Line_Valid  output  1  one-cycle pulse, IC_Line_Data valid
DC_Req_Valid  input  1  D-cache request; held until DC_Line_Valid or DC_WR_Done
DC_Req_WR  input  1  1 = single-word write, 0 = line refill
DC_Req_ADD  input  WIDTH_ADD  D-cache address
DC_Req_WData  input  WIDTH_DATA  write data
DC_Grant  output  1  D-cache transaction in progress
DC_Line_Data  output  WIDTH_DATA*NUMBER_WORD  refilled line
DC_Line_Valid  output  1  one-cycle pulse
DC_WR_Done  output  1  one-cycle pulse, write acknowledged
MEM_Req_Valid  output  1  memory command valid
MEM_Req_Ready  input  1  memory accepts command when high with MEM_Req_Valid
MEM_Req_WR  output  1  1 = write, 0 = line read
MEM_Req_ADD  output  WIDTH_ADD  command address
MEM_Req_WData  output  WIDTH_DATA  write data
MEM_RD_Valid  input  1  read beat valid
MEM_RD_Data  input  WIDTH_DATA  read beat data
MEM_WR_Ack  input  1  write complete

Behaviour:
- Reset (RST low, async) clears all of the following, regardless of state; memory beats after reset release are ignored until a new command is issued:
  - all outputs and the line buffer to 0
  - state to IDLE
  - beat counter to 0
  - last_grant to DC, so IC wins the first tie
- Line_Data outputs are driven from the shared line buffer; they are valid only in the pulse cycle.
- FSM states:
  - IDLE: if exactly one Req_Valid is high, grant that requester. If both are high, grant the requester not equal to last_grant. On grant:
    - latch requester ID, op, address and WData
    - update last_grant
    - assert the Grant output
    - go to REQ
  - REQ: MEM_Req_Valid=1. MEM_Req_ADD is the latched address with the low log2(NUMBER_WORD)+2 bits zeroed for reads, and the low 2 bits zeroed for writes. Hold MEM_Req_Valid, ADD, WR and WData stable until MEM_Req_Ready. On Ready: drop MEM_Req_Valid next cycle and go to FILL (read) or WAIT_WR (write).
  - FILL: each MEM_RD_Valid writes MEM_RD_Data into buffer word [counter], then increments counter. When the beat with counter==NUMBER_WORD-1 is accepted, go to DONE. Counter is log2(NUMBER_WORD) bits and resets to 0 on entry to DONE.
  - WAIT_WR: on MEM_WR_Ack go to DONE.
  - DONE: one cycle.
    - Pulse IC_Line_Valid, DC_Line_Valid or DC_WR_Done according to the latched ID/op.
    - Deassert Grant at the end of the cycle.
    - Return to IDLE.
- Latency:
  - Grant is high from the cycle after acceptance in IDLE.
  - MEM_Req_Valid rises 1 cycle after acceptance.
  - Completion pulse comes 1 cycle after the last beat or the ack.
  - At least one IDLE cycle separates transactions.
- Boundary conditions:
  - MEM_RD_Valid outside FILL and MEM_WR_Ack outside WAIT_WR are ignored.
  - A requester dropping Req_Valid mid-transaction does not abort it; the result is still delivered.
  - A new request arriving during a transaction waits for IDLE.
  - Only one Grant is high at any time.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE, REQ, FILL, WAIT_WR, DONE)
  - requester ID constants (REQ_IC=0, REQ_DC=1)
  - line-offset width function clog2(NUMBER_WORD)+2
- One sub-module: rr_arbiter_2. It is combinational 2-way round-robin over {req_ic, req_dc, last_grant} and produces a one-hot grant. The last_grant register stays in the top.

Test Plan:
- Reset: RST low mid-FILL after 3 beats -> all outputs 0, state IDLE; the next IC request fetches a fresh line with buffer initially 0.
- IC refill: IC_Req_ADD=0x0000_1234, Ready high immediately, beats 0x11..0x88 one per cycle -> MEM_Req_ADD=0x0000_1220, MEM_Req_WR=0; IC_Line_Data={0x88,...,0x11} with 0x11 in LSBs; IC_Line_Valid pulses once, 1 cycle after the 8th beat.
- DC write: DC_Req_WR=1, ADD=0x0000_2006, WData=0xDEADBEEF, Ready delayed 3 cycles, Ack 2 cycles later -> Req fields stable for all 4 REQ cycles; MEM_Req_ADD=0x0000_2004; DC_WR_Done pulses once; no Line_Valid.
- Contention: IC and DC both request out of reset and re-request immediately -> grant order IC, DC, IC, DC; Grants never overlap.
- Gapped beats: beats arrive with MEM_RD_Valid low for 2 cycles between beats, plus a stray MEM_RD_Valid during REQ -> stray beat ignored; line correct; counter wraps to 0 for the next refill.
- Requester drop: DC drops DC_Req_Valid during FILL -> fill completes and DC_Line_Valid still pulses; IC is granted in the following IDLE cycle.
